string_char_streamer: RTL
=========================

// Module: string_char_streamer
// PURPOSE
//   Reader side of the string ROM. On request, fetches one packed string
//   (MAX_CHAR x CHAR_WIDTH codes, leftmost char in the MSBs) and streams it out
//   one character per valid/ready handshake with its column index. Feeds the
//   glyph/font renderer, which draws text on screen one character at a time.
//   Codes 0-25 = A-Z; BLANK_CODE = space; all other codes pass through unchanged.
// PARAMETERS
//   STRING_NUM     13   strings held in the ROM
//   MAX_CHAR       11   characters per string
//   CHAR_WIDTH     5    bits per character code
//   BLANK_CODE     31   space code
//   ROM_LATENCY    1    cycles from rom_addr stable to rom_data valid (0..3)
//   TRIM_TRAILING  1    1 = do not emit trailing BLANK_CODE chars
// PORTS (AW = $clog2(STRING_NUM+1), CW = $clog2(MAX_CHAR))
//   clk        in   1                    system clock, rising edge
//   rst        in   1                    asynchronous reset, active-high
//   req_valid  in   1                    string request
//   req_ready  out  1                    high only in IDLE
//   req_addr   in   AW                   string index
//   rom_addr   out  AW                   to string_rom addr
//   rom_data   in   CHAR_WIDTH*MAX_CHAR  from string_rom string_out
//   char_valid out  1                    char_code/char_col valid
//   char_ready in   1                    renderer accepts character
//   char_code  out  CHAR_WIDTH           character code
//   char_col   out  CW                   column, 0 = leftmost
//   char_last  out  1                    final emitted char of the string
//   done       out  1                    1-cycle pulse: request finished
//   err        out  1                    1-cycle pulse with done: bad req_addr
// BEHAVIOUR
//   Reset: state IDLE; req_ready=1 after reset release; all other outputs 0
//     (char_code, char_col, rom_addr = 0).
//   FSM: IDLE -> FETCH -> STREAM -> IDLE.
//   IDLE: req_valid&req_ready latches req_addr into rom_addr (held until the next
//     accept). If req_addr >= STRING_NUM: no fetch, no chars; done=err=1 on the
//     next cycle, return to IDLE.
//   FETCH: wait ROM_LATENCY cycles, then capture rom_data into a shift/hold
//     register. rom_data is ignored at every other time.
//   Char i = captured[(MAX_CHAR-1-i)*CHAR_WIDTH +: CHAR_WIDTH].
//   last_col = MAX_CHAR-1 if TRIM_TRAILING=0, else index of the rightmost
//     non-blank char. All-blank string with trim: no chars; done pulses on the
//     cycle after capture; back to IDLE.
//   STREAM: char_valid=1 from the cycle after capture. char_code/char_col/
//     char_last stay stable while char_valid & !char_ready (AXI-style; valid never
//     drops before the handshake). On handshake, col+1 is presented in the next
//     cycle, so with char_ready held high there is one char per cycle.
//     Interior blanks are always emitted.
//   char_last=1 exactly when char_col==last_col.
//   The handshake on the last char -> char_valid=0, done=1 in the next cycle,
//     IDLE (req_ready=1 in the same cycle as done).
//   Latency (ROM_LATENCY=1): accept at edge N -> first char_valid at edge N+2.
//   req_valid outside IDLE is ignored (req_ready=0); no queueing.
//   rst mid-stream: immediate abort to reset values; no done pulse.
//   Column counter never exceeds MAX_CHAR-1; no wrap.
// TESTING
//   1 Reset: assert rst asynchronously mid-cycle -> all outputs 0 at once;
//     req_ready=1 after release.
//   2 addr=0 ("GAME TIME: "), trim=1, char_ready=1 -> codes 6,0,12,4,31,19,8,12,4,26
//     on cols 0..9 in consecutive cycles; char_last at col 9; done next cycle.
//   3 addr=12 ("INSTRUCTION"), char_ready toggling 1/0 -> 11 chars, each held
//     stable while stalled; char_last at col 10; no duplicates or drops.
//   4 addr=7 (all code 27), trim=0 -> 11 chars of 27; a second req_valid pulsed
//     mid-stream is ignored (req_ready=0).
//   5 addr=13 (>= STRING_NUM) -> no char_valid; done=err=1 for one cycle; then
//     addr=0 serves normally. All-blank ROM entry with trim=1 -> done, no chars.
//   6 rst asserted at col 4 of addr=0 -> char_valid drops at once, no done;
//     a new request after release starts at col 0.

Source files
------------

// File: rtl/string_char_streamer.sv
// Reads one packed string from the string ROM and streams its characters, leftmost
// first, over a valid/ready handshake with column index and last-character flag.
module string_char_streamer #(
    parameter int unsigned STRING_NUM    = 13,
    parameter int unsigned MAX_CHAR      = 11,
    parameter int unsigned CHAR_WIDTH    = 5,
    parameter int unsigned BLANK_CODE    = 31,
    parameter int unsigned ROM_LATENCY   = 1,
    parameter bit          TRIM_TRAILING = 1'b1,
    localparam int unsigned AW = $clog2(STRING_NUM + 1),
    localparam int unsigned CW = $clog2(MAX_CHAR),
    localparam int unsigned DW = CHAR_WIDTH * MAX_CHAR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [AW-1:0]         req_addr,
    output logic [AW-1:0]         rom_addr,
    input  logic [DW-1:0]         rom_data,
    output logic                  char_valid,
    input  logic                  char_ready,
    output logic [CHAR_WIDTH-1:0] char_code,
    output logic [CW-1:0]         char_col,
    output logic                  char_last,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {StIdle, StFetch, StStream} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   rom_addr_q, rom_addr_d;
    logic [1:0]      lat_q, lat_d;
    logic [DW-1:0]   data_q, data_d;
    logic [CW-1:0]   col_q, col_d;
    logic [CW-1:0]   last_q, last_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [CW-1:0]   scan_last;
    logic            scan_any;
    logic            handshake;

    // Rightmost non-blank column of the word arriving from the ROM.
    always_comb begin
        scan_last = '0;
        scan_any  = 1'b0;
        for (int unsigned i = 0; i < MAX_CHAR; i++) begin
            if (rom_data[(MAX_CHAR-1-i)*CHAR_WIDTH +: CHAR_WIDTH] !=
                CHAR_WIDTH'(BLANK_CODE)) begin
                scan_any  = 1'b1;
                scan_last = CW'(i);
            end
        end
    end

    assign char_valid = (state_q == StStream);
    assign handshake  = char_valid & char_ready;

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        lat_d      = lat_q;
        data_d     = data_q;
        col_d      = col_q;
        last_d     = last_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    rom_addr_d = req_addr;
                    if (req_addr >= AW'(STRING_NUM)) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        lat_d   = '0;
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                if (lat_q == 2'(ROM_LATENCY)) begin
                    data_d = rom_data;
                    col_d  = '0;
                    if (TRIM_TRAILING && !scan_any) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        last_d  = TRIM_TRAILING ? scan_last : CW'(MAX_CHAR - 1);
                        state_d = StStream;
                    end
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            StStream: begin
                if (handshake) begin
                    if (col_q == last_q) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        col_d  = col_q + CW'(1);
                        data_d = data_q << CHAR_WIDTH;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            rom_addr_q <= '0;
            lat_q      <= '0;
            data_q     <= '0;
            col_q      <= '0;
            last_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            lat_q      <= lat_d;
            data_q     <= data_d;
            col_q      <= col_d;
            last_q     <= last_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Held low while rst is asserted so every output reads zero during reset.
    assign req_ready = (state_q == StIdle) & ~rst;
    assign rom_addr  = rom_addr_q;
    assign char_code = char_valid ? data_q[DW-1 -: CHAR_WIDTH] : '0;
    assign char_col  = col_q;
    assign char_last = char_valid & (col_q == last_q);
    assign done      = done_q;
    assign err       = err_q;

endmodule
